// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream decimators: sample extension and the
// output-width sanity check used at elaboration.
package axis_pkg;

  localparam int EXT_MAX_W = 64;

  function automatic logic [EXT_MAX_W-1:0] axis_extend(
    input logic [EXT_MAX_W-1:0] i_data,
    input int                   i_width,
    input logic                 i_signed
  );
    logic [EXT_MAX_W-1:0] w_res;
    logic [5:0]           w_msb;
    w_msb = 6'(i_width - 1);
    w_res = i_data;
    for (int k = 0; k < EXT_MAX_W; k++) begin
      if (i_signed && (k >= i_width) && i_data[w_msb]) w_res[k] = 1'b1;
    end
    return w_res;
  endfunction

  // Output must hold N full-scale samples without losing the top bits.
  function automatic bit axis_width_ok(input int i_m, input int i_s, input int i_c);
    return ((i_m - i_s - i_c) >= 0) && (i_m <= EXT_MAX_W);
  endfunction

endpackage

// File: rtl/axis_accumulator_if.sv
// AXI-Stream bundle; tlast exists only when AXIS_ACCUMULATOR_TLAST_EN is defined.
interface axis_accumulator_if #(parameter int DW = 16);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  logic          tlast;
`endif

  modport master (
    output tdata,
    output tvalid,
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    output tlast,
`endif
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    input  tlast,
`endif
    output tready
  );
endinterface

// File: rtl/axis_accumulator_hold.sv
// Single-entry output holding register with ready/valid; a load may coincide
// with a drain so the stream keeps one beat per cycle.
module axis_accumulator_hold #(
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  input  logic          i_last,
`endif
  output logic          o_blocked,
  axis_accumulator_if.master m_axis
);

  logic          r_valid;
  logic [DW-1:0] r_data;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  logic          r_last;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
      r_last  <= 1'b0;
`endif
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
      r_last  <= i_last;
`endif
    end else if (m_axis.tready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_axis.tvalid = r_valid;
  assign m_axis.tdata  = r_data;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  assign m_axis.tlast  = r_last;
`endif
  assign o_blocked     = r_valid && !m_axis.tready;

endmodule

// File: rtl/axis_accumulator.sv
// Sums N consecutive AXI-Stream samples into one wide output beat.
// Optional frame tagging on the output with AXIS_ACCUMULATOR_TLAST_EN.
//   state      | meaning
//   EMPTY_ACC  | holding register empty, accumulating
//   FULL_ACC   | holding register full, accumulating non-last beats
//   FULL_STALL | holding register full, last beat waiting for drain
// The state is implied by r_cnt and the holding register valid flag.
module axis_accumulator
  import axis_pkg::*;
#(
  parameter int    S_AXIS_TDATA_WIDTH = 16,
  parameter int    M_AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH         = 16,
  parameter string AXIS_TDATA_SIGNED  = "TRUE"
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  input  logic [15:0]           cfg_frame,
`endif
  axis_accumulator_if.slave     s_axis,
  axis_accumulator_if.master    m_axis
);

  localparam int  MW       = M_AXIS_TDATA_WIDTH;
  localparam bit  WIDTH_OK = axis_width_ok(M_AXIS_TDATA_WIDTH, S_AXIS_TDATA_WIDTH, CNTR_WIDTH);
  localparam logic IS_SIGNED = (AXIS_TDATA_SIGNED == "TRUE");

  if (!WIDTH_OK) begin : g_bad_width
    $error("axis_accumulator: M_AXIS_TDATA_WIDTH too small for S_AXIS_TDATA_WIDTH + CNTR_WIDTH");
  end

  logic                  r_rdy_en;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH-1:0] r_n;
  logic [MW-1:0]         r_acc;

  logic [CNTR_WIDTH-1:0] w_n_cfg;
  logic [CNTR_WIDTH-1:0] w_n_cur;
  logic                  w_last;
  logic                  w_blocked;
  logic                  w_accept;
  logic                  w_load;
  logic [MW-1:0]         w_ext;
  logic [MW-1:0]         w_sum;

  // On the first beat of a sum the fresh cfg_data decides whether it is also the last.
  assign w_n_cfg  = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;
  assign w_n_cur  = (r_cnt == '0) ? w_n_cfg : r_n;
  assign w_last   = (r_cnt == (w_n_cur - CNTR_WIDTH'(1)));

  assign s_axis.tready = r_rdy_en && (!w_blocked || !w_last);
  assign w_accept = s_axis.tvalid && s_axis.tready;
  assign w_load   = w_accept && w_last;

  assign w_ext = MW'(axis_extend(EXT_MAX_W'(s_axis.tdata), S_AXIS_TDATA_WIDTH, IS_SIGNED));
  assign w_sum = r_acc + w_ext;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en <= 1'b0;
      r_cnt    <= '0;
      r_n      <= CNTR_WIDTH'(1);
      r_acc    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        if (r_cnt == '0) r_n <= w_n_cfg;
        if (w_last) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else begin
          r_cnt <= r_cnt + CNTR_WIDTH'(1);
          r_acc <= w_sum;
        end
      end
    end
  end

`ifdef AXIS_ACCUMULATOR_TLAST_EN
  logic [15:0] r_frm_cnt;
  logic [15:0] r_frm_n;
  logic [15:0] w_frm_cfg;
  logic [15:0] w_frm_cur;
  logic        w_frm_last;

  // Sums are counted as they enter the holding register; order is preserved.
  assign w_frm_cfg  = (cfg_frame == '0) ? 16'd1 : cfg_frame;
  assign w_frm_cur  = (r_frm_cnt == '0) ? w_frm_cfg : r_frm_n;
  assign w_frm_last = (r_frm_cnt == (w_frm_cur - 16'd1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frm_cnt <= '0;
      r_frm_n   <= 16'd1;
    end else if (w_load) begin
      if (r_frm_cnt == '0) r_frm_n <= w_frm_cfg;
      r_frm_cnt <= w_frm_last ? 16'd0 : (r_frm_cnt + 16'd1);
    end
  end
`endif

  axis_accumulator_hold #(.DW(MW)) u_hold (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_load    (w_load),
    .i_data    (w_sum),
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    .i_last    (w_frm_last),
`endif
    .o_blocked (w_blocked),
    .m_axis    (m_axis)
  );

endmodule

// File: tb/tb_axis_accumulator.sv
// Directed bench for axis_accumulator: a signed and an unsigned instance share one stimulus.
module tb_axis_accumulator;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] tb_cfg = 16'd1;
  logic [15:0] tb_frame = 16'd1;
  logic [15:0] tb_tdata = 16'd0;
  logic        tb_tvalid = 1'b0;
  logic        tb_mready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_data[$];
  bit          q_last[$];

  always #5 aclk = ~aclk;

  axis_accumulator_if #(.DW(16)) s_if ();
  axis_accumulator_if #(.DW(32)) m_if ();
  axis_accumulator_if #(.DW(16)) s_u ();
  axis_accumulator_if #(.DW(32)) m_u ();

  assign s_if.tdata  = tb_tdata;
  assign s_if.tvalid = tb_tvalid;
  assign m_if.tready = tb_mready;
  assign s_u.tdata   = tb_tdata;
  assign s_u.tvalid  = tb_tvalid;
  assign m_u.tready  = tb_mready;
`ifdef AXIS_ACCUMULATOR_TLAST_EN
  assign s_if.tlast  = 1'b0;
  assign s_u.tlast   = 1'b0;
`endif

  axis_accumulator #(
    .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16), .AXIS_TDATA_SIGNED("TRUE")
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(tb_cfg),
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    .cfg_frame(tb_frame),
`endif
    .s_axis(s_if), .m_axis(m_if)
  );

  axis_accumulator #(
    .S_AXIS_TDATA_WIDTH(16), .M_AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16), .AXIS_TDATA_SIGNED("FALSE")
  ) dut_u (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(tb_cfg),
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    .cfg_frame(tb_frame),
`endif
    .s_axis(s_u), .m_axis(m_u)
  );

  always @(posedge aclk) begin
    if (m_if.tvalid && m_if.tready) begin
      q_data.push_back(m_if.tdata);
`ifdef AXIS_ACCUMULATOR_TLAST_EN
      q_last.push_back(m_if.tlast);
`else
      q_last.push_back(1'b0);
`endif
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d);
    int waited;
    waited = 0;
    tb_tvalid = 1'b1;
    tb_tdata  = d;
    @(negedge aclk);
    while (s_if.tready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge aclk);
    end
    if (waited >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_beat_timeout: tready=%b required 1", s_if.tready);
    end
    tick();
    tb_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b required 0", m_if.tvalid); end
    n_cmp++; if (m_if.tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata: got %h required 0", m_if.tdata); end
    aresetn = 1'b1;
    #1;
    n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL reset_tready_early: got %b required 0", s_if.tready); end
    @(negedge aclk);
    n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL reset_tready_after: got %b required 1", s_if.tready); end
    tick();
  endtask

  task automatic test_sum4();
    q_data.delete();
    tb_cfg = 16'd4;
    tb_mready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_tvalid = 1'b1;
      tb_tdata  = 16'(i + 1);
      @(negedge aclk);
      n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL sum4_tready beat %0d: got %b required 1", i, s_if.tready); end
      n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL sum4_early_valid beat %0d: got %b required 0", i, m_if.tvalid); end
      tick();
    end
    tb_tvalid = 1'b0;
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL sum4_valid: got %b required 1", m_if.tvalid); end
    n_cmp++; if (m_if.tdata !== 32'd10) begin n_err++; $display("FAIL sum4_data: got %0d required 10", m_if.tdata); end
    tick();
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL sum4_valid_drop: got %b required 0", m_if.tvalid); end
    n_cmp++; if (q_data.size() !== 1) begin n_err++; $display("FAIL sum4_count: got %0d required 1", q_data.size()); end
    tick();
  endtask

  task automatic test_signed();
    tb_cfg = 16'd2;
    tb_mready = 1'b1;
    send_beat(16'hFFFF);
    send_beat(16'hFFFF);
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL signed_valid: got %b required 1", m_if.tvalid); end
    n_cmp++; if (m_if.tdata !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL signed_data: got %h required fffffffe", m_if.tdata); end
    n_cmp++; if (m_u.tdata !== 32'h0001_FFFE) begin n_err++; $display("FAIL unsigned_data: got %h required 0001fffe", m_u.tdata); end
    tick();
    tick();
  endtask

  task automatic test_stall();
    q_data.delete();
    tb_cfg = 16'd1;
    tb_mready = 1'b0;
    tb_tvalid = 1'b1;
    tb_tdata = 16'd5;
    @(negedge aclk);
    n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL stall_first_rdy: got %b required 1", s_if.tready); end
    tick();
    tb_tdata = 16'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL stall_rdy cyc %0d: got %b required 0", i, s_if.tready); end
      n_cmp++; if (m_if.tdata !== 32'd5) begin n_err++; $display("FAIL stall_hold cyc %0d: got %0d required 5", i, m_if.tdata); end
      tick();
    end
    tb_mready = 1'b1;
    @(negedge aclk);
    n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL stall_release_rdy: got %b required 1", s_if.tready); end
    tick();
    tb_tdata = 16'd7;
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd6) begin n_err++; $display("FAIL stall_out6: got v=%b d=%0d required v=1 d=6", m_if.tvalid, m_if.tdata); end
    tick();
    tb_tvalid = 1'b0;
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd7) begin n_err++; $display("FAIL stall_out7: got v=%b d=%0d required v=1 d=7", m_if.tvalid, m_if.tdata); end
    tick();
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b required 0", m_if.tvalid); end
    n_cmp++;
    if (q_data.size() !== 3 || q_data[0] !== 32'd5 || q_data[1] !== 32'd6 || q_data[2] !== 32'd7) begin
      n_err++; $display("FAIL stall_sequence: got %0d items required 5,6,7", q_data.size());
    end
    tick();
  endtask

  task automatic test_cfg_change();
    q_data.delete();
    tb_mready = 1'b1;
    tb_cfg = 16'd3;
    send_beat(16'd10);
    tb_cfg = 16'd2;
    send_beat(16'd20);
    send_beat(16'd30);
    send_beat(16'd1);
    send_beat(16'd2);
    repeat (3) tick();
    n_cmp++; if (q_data.size() !== 2) begin n_err++; $display("FAIL cfg_count: got %0d required 2", q_data.size()); end
    n_cmp++; if (q_data.size() > 0 && q_data[0] !== 32'd60) begin n_err++; $display("FAIL cfg_sum3: got %0d required 60", q_data[0]); end
    n_cmp++; if (q_data.size() > 1 && q_data[1] !== 32'd3) begin n_err++; $display("FAIL cfg_sum2: got %0d required 3", q_data[1]); end
  endtask

  task automatic test_async_reset();
    tb_cfg = 16'd2;
    tb_mready = 1'b0;
    send_beat(16'd100);
    send_beat(16'd200);
    send_beat(16'd9);
    @(negedge aclk);
    n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd300) begin n_err++; $display("FAIL areset_pending: got v=%b d=%0d required v=1 d=300", m_if.tvalid, m_if.tdata); end
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL areset_drop: got %b required 0", m_if.tvalid); end
    @(negedge aclk);
    aresetn = 1'b1;
    q_data.delete();
    tb_mready = 1'b1;
    send_beat(16'd3);
    send_beat(16'd4);
    repeat (3) tick();
    n_cmp++;
    if (q_data.size() !== 1 || q_data[0] !== 32'd7) begin
      n_err++; $display("FAIL areset_fresh_sum: got %0d items first=%0d required 1 item 7", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'd0);
    end
  endtask

`ifdef AXIS_ACCUMULATOR_TLAST_EN
  task automatic test_tlast();
    q_data.delete();
    q_last.delete();
    tb_cfg = 16'd1;
    tb_frame = 16'd3;
    tb_mready = 1'b1;
    for (int i = 1; i <= 7; i++) send_beat(16'(i));
    repeat (3) tick();
    n_cmp++; if (q_last.size() !== 7) begin n_err++; $display("FAIL tlast_count: got %0d required 7", q_last.size()); end
    for (int i = 0; i < 7 && i < q_last.size(); i++) begin
      n_cmp++;
      if (q_last[i] !== ((i == 2) || (i == 5))) begin
        n_err++; $display("FAIL tlast_out%0d: got %b required %b", i + 1, q_last[i], ((i == 2) || (i == 5)));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sum4();
    test_signed();
    test_stall();
    test_cfg_change();
    test_async_reset();
`ifdef AXIS_ACCUMULATOR_TLAST_EN
    test_tlast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
